// File: rtl/song_sequencer.sv
// song_sequencer
//
// Upstream feeder for note_player. Walks one song held in a synchronous song
// ROM. For each entry it presents the note/duration pair together with a
// one-cycle load_new_note pulse. It then waits for note_player's
// done_with_note level before fetching the next entry. A zero duration marks
// the end of a song. A song that fills every slot ends after its last index.
//
// Ports:
//   clk               system clock
//   reset             synchronous, active-high reset
//   play              1 = advance through the song, 0 = pause (takes effect in WAIT)
//   song_sel          song to play; changing it mid-song restarts from IDLE
//   rom_addr          {song, note_idx} to the song ROM, registered
//   rom_data          ROM word, [11:6] note, [5:0] duration; valid 1 cycle after rom_addr
//   note_to_load      note for note_player, registered
//   duration_to_load  duration in beats, registered
//   load_new_note     one-cycle pulse; note/duration are valid in the same cycle
//   done_with_note    level from note_player; high = current note finished
//   song_done         high from end of song until reset or song change
module song_sequencer #(
    parameter int SONG_SEL_WIDTH = 2,
    parameter int NOTE_IDX_WIDTH = 5
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     play,
    input  logic [SONG_SEL_WIDTH-1:0]                song_sel,
    output logic [SONG_SEL_WIDTH+NOTE_IDX_WIDTH-1:0] rom_addr,
    input  logic [11:0]                              rom_data,
    output logic [5:0]                               note_to_load,
    output logic [5:0]                               duration_to_load,
    output logic                                     load_new_note,
    input  logic                                     done_with_note,
    output logic                                     song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_LOAD,
        S_GUARD,
        S_WAIT,
        S_END
    } state_t;

    localparam logic [NOTE_IDX_WIDTH-1:0] LAST_IDX = '1;
    localparam logic [NOTE_IDX_WIDTH-1:0] FIRST_IDX = '0;

    state_t                    state;
    logic [NOTE_IDX_WIDTH-1:0] note_idx;
    logic [NOTE_IDX_WIDTH-1:0] next_idx;
    logic [SONG_SEL_WIDTH-1:0] song;
    logic                      song_changed;
    logic [5:0]                rom_note;
    logic [5:0]                rom_duration;

    assign next_idx     = note_idx + 1'b1;
    assign rom_note     = rom_data[11:6];
    assign rom_duration = rom_data[5:0];

    // IDLE tracks song_sel every cycle, so only the other states can see a change.
    assign song_changed = (state != S_IDLE) && (song_sel != song);

    // NOTE: every register below is assigned with <= so all of them update
    // together on the clock edge, and each sees the others' pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            note_idx         <= '0;
            song             <= '0;
            rom_addr         <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            load_new_note    <= 1'b0;
            song_done        <= 1'b0;
        end else if (song_changed) begin
            // Abandon whatever was in flight, including a load about to pulse.
            state         <= S_IDLE;
            note_idx      <= '0;
            song          <= song_sel;
            rom_addr      <= {song_sel, FIRST_IDX};
            load_new_note <= 1'b0;
            song_done     <= 1'b0;
        end else begin
            // The pulse is raised only on the READ->LOAD edge, so it lasts one cycle.
            load_new_note <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    note_idx <= '0;
                    song     <= song_sel;
                    rom_addr <= {song_sel, FIRST_IDX};
                    if (play) begin
                        state <= S_FETCH;
                    end
                end

                // The ROM registers rom_addr at the end of this cycle.
                S_FETCH: state <= S_READ;

                S_READ: begin
                    if (rom_duration == 6'd0) begin
                        // End marker: the last loaded note stays on the outputs.
                        state     <= S_END;
                        song_done <= 1'b1;
                    end else begin
                        note_to_load     <= rom_note;
                        duration_to_load <= rom_duration;
                        load_new_note    <= 1'b1;
                        state            <= S_LOAD;
                    end
                end

                S_LOAD: state <= S_GUARD;

                // done_with_note may still be high from the previous note here.
                S_GUARD: state <= S_WAIT;

                S_WAIT: begin
                    if (done_with_note && play) begin
                        if (note_idx == LAST_IDX) begin
                            // A full song ends here instead of wrapping to index 0.
                            state     <= S_END;
                            song_done <= 1'b1;
                        end else begin
                            note_idx <= next_idx;
                            rom_addr <= {song, next_idx};
                            state    <= S_FETCH;
                        end
                    end
                end

                S_END: song_done <= 1'b1;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer
//
// Self-checking bench for song_sequencer. A synchronous ROM model and a
// note_player model drive the DUT. The expected load sequence for each song
// comes from the ROM contents: entries from index 0 up to the first zero
// duration, or all 32 entries. Expected latencies come from the trigger
// cycle: a play rise in IDLE, or done&play seen in WAIT.
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic [1:0]  song_sel = 2'd0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data = '0;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        load_new_note;
    logic        done_with_note = 1'b1;
    logic        song_done;

    song_sequencer #(
        .SONG_SEL_WIDTH(2),
        .NOTE_IDX_WIDTH(5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song_sel         (song_sel),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .done_with_note   (done_with_note),
        .song_done        (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM: 4 songs x 32 entries.
    logic [11:0] rom [0:127];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state.
    logic [11:0] exp_q [$];
    int exp_n, end_idx, cur_song, max_idx, loads;
    int trig_cyc, guard_end;
    bit armed;

    // note_player model state.
    bit np_busy;
    int np_left, np_hold, np_lag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock. Outputs are observed 1 time unit after the edge.
    task automatic step();
        logic [11:0] e;
        // The trigger counts only once the GUARD cycle after a load is over.
        if (armed && play && done_with_note && cyc >= guard_end) begin
            trig_cyc = cyc;
            armed    = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rom_addr[6:5] == 2'(cur_song) && int'(rom_addr[4:0]) > max_idx)
            max_idx = int'(rom_addr[4:0]);
        if (load_new_note) begin
            loads++;
            if (exp_q.size() == 0) begin
                check("extra_load", loads, exp_n);
            end else begin
                e = exp_q.pop_front();
                check("load_entry", {note_to_load, duration_to_load}, e);
            end
            check("load_latency", cyc - trig_cyc, 3);
            armed     = 1'b1;
            guard_end = cyc + 2;
            np_busy   = 1'b1;
            np_left   = int'(duration_to_load);
            np_hold   = np_lag;
            if (np_lag == 0) done_with_note = 1'b0;
        end else if (np_busy) begin
            if (np_hold > 0) begin
                np_hold--;
                if (np_hold == 0) done_with_note = 1'b0;
            end else begin
                np_left--;
                if (np_left <= 0) begin
                    done_with_note = 1'b1;
                    np_busy        = 1'b0;
                end
            end
        end
    endtask

    task automatic fill_song(input int s, input int n);
        logic [5:0] nt, du;
        for (int i = 0; i < 32; i++) begin
            nt = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            du = 6'($urandom_range(1, 8));
            if (i == n) du = 6'd0;
            rom[s*32 + i] = {nt, du};
        end
    endtask

    // Expected loads: entries from index 0 up to the first zero duration.
    task automatic prep_model(input int s);
        logic [11:0] e;
        exp_q.delete();
        end_idx = 31;
        for (int i = 0; i < 32; i++) begin
            e = rom[s*32 + i];
            if (e[5:0] == 6'd0) begin
                end_idx = i;
                break;
            end
            exp_q.push_back(e);
        end
        exp_n          = exp_q.size();
        loads          = 0;
        cur_song       = s;
        max_idx        = 0;
        armed          = 1'b0;
        guard_end      = 0;
        np_busy        = 1'b0;
        done_with_note = 1'b1;
    endtask

    task automatic start_song(input int s);
        logic [1:0] sel;
        sel = 2'(s);
        prep_model(s);
        song_sel = sel;
        play     = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("idle_addr", rom_addr, {sel, 5'd0});
        check("idle_no_load", load_new_note, 0);
        play     = 1'b1;
        trig_cyc = cyc;
    endtask

    task automatic run_song(input bit rand_play, input bit pause_once, input int budget);
        int n;
        bit paused;
        logic [6:0] hold_addr;
        logic [1:0] sel;
        n      = 0;
        paused = 1'b0;
        while (!song_done && n < budget) begin
            if (pause_once && !paused && loads == 1 && armed && done_with_note && cyc >= guard_end) begin
                play      = 1'b0;
                hold_addr = rom_addr;
                for (int i = 0; i < 20; i++) step();
                check("pause_no_load", loads, 1);
                check("pause_addr_stable", rom_addr, hold_addr);
                play   = 1'b1;
                paused = 1'b1;
            end
            step();
            n++;
            if (rand_play) play = ($urandom_range(0, 3) != 0);
        end
        sel = 2'(cur_song);
        check("song_done", song_done, 1);
        check("load_count", loads, exp_n);
        check("end_addr", rom_addr, {sel, 5'(end_idx)});
        check("max_idx", max_idx, end_idx);
        // END ignores play and holds its outputs.
        for (int i = 0; i < 8; i++) begin
            play = 1'($urandom_range(0, 1));
            step();
        end
        check("song_done_hold", song_done, 1);
        check("end_addr_hold", rom_addr, {sel, 5'(end_idx)});
        check("no_load_after_end", loads, exp_n);
    endtask

    initial begin
        int n;
        for (int s = 0; s < 4; s++) fill_song(s, $urandom_range(1, 20));
        fill_song(0, 3);
        rom[0] = {6'd10, 6'd4};
        rom[1] = {6'd20, 6'd8};
        rom[2] = {6'd0,  6'd2};
        rom[3] = {6'd63, 6'd0};
        np_lag = 0;
        cur_song = 0;

        // Reset state; song_sel is non-zero to show reset wins over IDLE tracking.
        song_sel = 2'd3;
        reset    = 1'b1;
        step();
        step();
        check("rst_addr", rom_addr, 0);
        check("rst_note", note_to_load, 0);
        check("rst_dur", duration_to_load, 0);
        check("rst_load", load_new_note, 0);
        check("rst_done", song_done, 0);

        // Song 0 with the three-entry table, then again with done held high through GUARD.
        start_song(0);
        run_song(1'b0, 1'b0, 2000);
        np_lag = 2;
        start_song(0);
        run_song(1'b0, 1'b0, 2000);
        np_lag = 0;

        // Pause in WAIT with done high, then resume.
        fill_song(1, 6);
        start_song(1);
        run_song(1'b0, 1'b1, 2000);

        // Song change 0 -> 2 while waiting on the first note.
        fill_song(2, 5);
        start_song(0);
        n = 0;
        while (!(loads == 1 && cyc >= guard_end) && n < 50) begin
            step();
            n++;
        end
        check("sc_in_wait", loads, 1);
        song_sel = 2'd2;
        step();
        check("sc_addr", rom_addr, 7'h40);
        check("sc_song_done", song_done, 0);
        check("sc_no_load", load_new_note, 0);
        prep_model(2);
        trig_cyc = cyc;
        run_song(1'b0, 1'b0, 2000);

        // Full 32-entry song without an end marker.
        fill_song(3, 32);
        start_song(3);
        run_song(1'b0, 1'b0, 4000);

        // Reset while load_new_note is high, then replay from index 0.
        start_song(0);
        n = 0;
        while (!load_new_note && n < 20) begin
            step();
            n++;
        end
        check("reached_load", load_new_note, 1);
        song_sel = 2'd2;
        reset    = 1'b1;
        step();
        check("mid_rst_addr", rom_addr, 0);
        check("mid_rst_note", note_to_load, 0);
        check("mid_rst_dur", duration_to_load, 0);
        check("mid_rst_load", load_new_note, 0);
        check("mid_rst_done", song_done, 0);
        reset = 1'b0;
        start_song(0);
        run_song(1'b0, 1'b0, 2000);

        // Randomized songs, lengths, play toggling and done lag.
        for (int it = 0; it < 6; it++) begin
            fill_song(1, $urandom_range(0, 31));
            fill_song(2, $urandom_range(0, 31));
            fill_song(3, ($urandom_range(0, 2) == 0) ? 32 : $urandom_range(0, 31));
            np_lag = $urandom_range(0, 2);
            start_song($urandom_range(0, 3));
            run_song(1'b1, 1'b0, 6000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Upstream feeder for note_player. It walks a song stored in a synchronous song ROM and presents each note/duration pair with a one-cycle load_new_note pulse. It then waits for note_player's done_with_note level before fetching the next entry. Songs are selected by song_sel, and end-of-song is flagged on song_done.

Parameters:
SONG_SEL_WIDTH, 2, width of song select; 2^SONG_SEL_WIDTH songs in ROM
NOTE_IDX_WIDTH, 5, log2 of max entries per song (32)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
play  in  1  1 = advance through song; 0 = hold position (pause)
song_sel  in  SONG_SEL_WIDTH  song to play
rom_addr  out  SONG_SEL_WIDTH+NOTE_IDX_WIDTH  {song, note_idx}, registered
rom_data  in  12  [11:6] note, [5:0] duration; valid 1 cycle after rom_addr is sampled
note_to_load  out  6  note for note_player, registered
duration_to_load  out  6  duration in beats, registered
load_new_note  out  1  one-cycle pulse; note/duration valid in same cycle
done_with_note  in  1  level from note_player; high = current note finished
song_done  out  1  high from end of song until reset or song change

Behaviour:
- Reset: state IDLE, note_idx=0, rom_addr=0, note_to_load=0, duration_to_load=0, load_new_note=0, song_done=0, latched song=0.
- States: IDLE, FETCH, READ, LOAD, GUARD, WAIT, END.
- IDLE:
  - rom_addr={song_sel,0}, note_idx=0, latched song=song_sel.
  - play=1 -> FETCH; otherwise stay.
- FETCH: ROM samples rom_addr during this cycle -> READ (1 cycle).
- READ: rom_data is valid.
  - duration==0 (end marker) -> END; note/duration outputs keep their previous values.
  - Otherwise register note_to_load=rom_data[11:6] and duration_to_load=rom_data[5:0], then -> LOAD.
  - note==0 is a rest; it is still loaded normally.
- LOAD: load_new_note=1 for exactly this cycle -> GUARD.
- GUARD: one cycle; done_with_note is ignored (it may still be high from the previous note) -> WAIT.
- WAIT: on done_with_note=1 AND play=1:
  - note_idx == all-ones -> END (wrap guard; no fetch of index 0).
  - Otherwise note_idx+1, rom_addr={song,note_idx+1} -> FETCH.
  - While play=0, hold in WAIT regardless of done_with_note.
- END:
  - song_done=1, load_new_note=0; hold until reset or song change.
  - play has no effect.
- Song change: song_sel != latched song in any non-IDLE state -> IDLE next cycle. This clears note_idx and song_done. Any pending load is abandoned; no load_new_note pulse is issued that cycle.
- play=0 in FETCH/READ/LOAD/GUARD does not stall; the sequence completes into WAIT, and the pause takes effect there.
- Latency: play rise in IDLE -> load_new_note on the 4th clock (IDLE->FETCH->READ->LOAD). done_with_note sampled high in WAIT -> next load_new_note 3 cycles later.
- Contract with note_player: done_with_note deasserts within 1 cycle of load_new_note for any nonzero duration.
- Reset mid-operation: returns to the reset state on the next edge; outputs take their reset values.
- note_to_load and duration_to_load change only in READ (or on reset) and are otherwise stable.

Test Plan:
1. Song 0 = {(10,4),(20,8),(0,2),(x,0)}, play=1, done model asserts done N beats after load -> three load pulses with (10,4),(20,8),(0,2) in order; song_done=1 after the third done; rom_addr never passes 3.
2. Play rise at cycle t from IDLE -> rom_addr=0 at t; load_new_note high exactly at t+3 for 1 cycle; done_with_note held high through GUARD does not skip a note.
3. play=0 while done_with_note=1 in WAIT for 20 cycles -> no fetch, rom_addr stable; play=1 -> load pulse 3 cycles later with the next entry.
4. song_sel 0->2 mid-note (in WAIT) -> IDLE next cycle, rom_addr=0x40, song_done=0, no stray load; song 2 plays from index 0.
5. Song with 32 nonzero entries and no marker -> 32 loads, then END with song_done=1; rom_addr never wraps to {song,0}.
6. reset asserted in LOAD -> load_new_note=0, all outputs 0, state IDLE next cycle; replay from index 0 after release.
